// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Round-robin arbiter and command sequencer between two masters and one
//   single-port synchronous SRAM. One access may be issued per clock; read data
//   is routed back to the master that issued the read, in issue order.
//
//   Ports
//     clk, rst            clock (rising edge), asynchronous active-low reset
//     reqN/rwN/addrN/wdataN  request from master N (held until granted)
//     gntN                combinational grant; transfer when reqN && gntN
//     rvalidN/rdataN      read return for master N (one-cycle pulse)
//     sram_rw/addr/din    registered SRAM command
//     sram_dataout        SRAM read data
//
//   Optional build macro SRAM_ARB_STATS_EN adds saturating 16-bit counters
//   gnt_cnt0, gnt_cnt1 (accepted transfers) and conflict_cnt (cycles with
//   both masters requesting).
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              sram_rw,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dataout
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1,
   output logic [15:0]       conflict_cnt
`endif
);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic              last_gnt;   // id of the most recent winner
   logic              accept;
   logic              win_id;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_din;

   logic              sram_rw_p0;
   logic [ADDR_W-1:0] sram_addr_p0;
   logic [DATA_W-1:0] sram_din_p0;

   // Read tag pipeline: stage k holds reads accepted k edges ago.
   logic [RD_LAT:0]   vld_p;
   logic [RD_LAT:0]   id_p;

   // Arbitration: under contention the master that did not win last goes.
   always_comb begin
      gnt0 = req0 & (~req1 | last_gnt);
      gnt1 = req1 & (~req0 | ~last_gnt);
   end

   assign accept   = gnt0 | gnt1;
   assign win_id   = gnt1;
   assign sel_rw   = win_id ? rw1    : rw0;
   assign sel_addr = win_id ? addr1  : addr0;
   assign sel_din  = win_id ? wdata1 : wdata0;

   // ---- stage p0: command register towards the SRAM ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt     <= 1'b1;
         sram_rw_p0   <= 1'b0;
         sram_addr_p0 <= '0;
         sram_din_p0  <= '0;
      end else if (accept) begin
         last_gnt     <= win_id;
         sram_rw_p0   <= sel_rw;
         sram_addr_p0 <= sel_addr;
         sram_din_p0  <= sel_din;
      end else begin
         // Idle: a dummy read at the held address; its data is never reported.
         sram_rw_p0   <= 1'b0;
      end
   end

   assign sram_rw   = sram_rw_p0;
   assign sram_addr = sram_addr_p0;
   assign sram_din  = sram_din_p0;

   // ---- stages p0..pRD_LAT: read tags travelling alongside the SRAM latency ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p <= '0;
      end else begin
         vld_p <= {vld_p[RD_LAT-1:0], accept & ~sel_rw};
      end
   end

   always_ff @(posedge clk) begin
      id_p <= {id_p[RD_LAT-1:0], win_id};
   end

   // ---- return stage: last tag stage lines up with valid SRAM data ----
   assign rvalid0 = vld_p[RD_LAT] & ~id_p[RD_LAT];
   assign rvalid1 = vld_p[RD_LAT] &  id_p[RD_LAT];
   assign rdata0  = sram_dataout;
   assign rdata1  = sram_dataout;

`ifdef SRAM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_cnt0     <= '0;
         gnt_cnt1     <= '0;
         conflict_cnt <= '0;
      end else begin
         if (gnt0)        gnt_cnt0     <= sat_inc(gnt_cnt0);
         if (gnt1)        gnt_cnt1     <= sat_inc(gnt_cnt1);
         if (req0 & req1) conflict_cnt <= sat_inc(conflict_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0, req1, rw0, rw1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          sram_rw;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dataout;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0]   gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .sram_rw(sram_rw), .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_dataout(sram_dataout)
`ifdef SRAM_ARB_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      return 8'(a * 29 + 90);
   endfunction

   // Synchronous SRAM: command sampled at the edge, read data one cycle later.
   logic [DW-1:0] mem [16];
   logic          mem_ok = 1'b0;
   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int a = 0; a < 16; a++) mem[a] <= init_val(a);
         mem_ok <= 1'b1;
      end else if (sram_rw) begin
         mem[sram_addr] <= sram_din;
      end else begin
         sram_dataout <= mem[sram_addr];
      end
   end

   // Reference model state
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] ref_mem [16];
   logic          m_last;
   int            cyc = 0;
   logic          ev0 [4];
   logic          ev1 [4];
   logic [DW-1:0] ed  [4];
   logic          prev_acc, prev_rw;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_wd;
   int            last_g;
   logic [DW-1:0] rd0_q [$];
   logic [DW-1:0] rd1_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_slots();
      for (int i = 0; i < 4; i++) begin
         ev0[i] = 1'b0;
         ev1[i] = 1'b0;
         ed[i]  = '0;
      end
   endtask

   // One clock cycle: check grants/returns/SRAM command mid-cycle, advance model.
   task automatic cycle();
      logic          eg0, eg1, id, rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            s, s2;
      @(negedge clk);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (req0 && req1) begin
         if (m_last == 1'b1) eg0 = 1'b1; else eg1 = 1'b1;
      end else begin
         eg0 = req0;
         eg1 = req1;
      end
      chk("gnt0", gnt0, eg0);
      chk("gnt1", gnt1, eg1);
      s = cyc % 4;
      chk("rvalid0", rvalid0, ev0[s]);
      chk("rvalid1", rvalid1, ev1[s]);
      if (ev0[s]) chk("rdata0", rdata0, ed[s]);
      if (ev1[s]) chk("rdata1", rdata1, ed[s]);
      if (rvalid0 === 1'b1) rd0_q.push_back(rdata0);
      if (rvalid1 === 1'b1) rd1_q.push_back(rdata1);
      if (prev_acc) begin
         chk("sram_rw", sram_rw, prev_rw);
         chk("sram_addr", sram_addr, prev_addr);
         if (prev_rw) chk("sram_din", sram_din, prev_wd);
      end else begin
         chk("sram_rw_idle", sram_rw, 1'b0);
      end
      ev0[s] = 1'b0;
      ev1[s] = 1'b0;
      last_g   = 2;
      prev_acc = 1'b0;
      if (eg0 || eg1) begin
         id = eg1;
         rw = id ? rw1 : rw0;
         a  = id ? addr1 : addr0;
         d  = id ? wdata1 : wdata0;
         m_last    = id;
         last_g    = id ? 1 : 0;
         prev_acc  = 1'b1;
         prev_rw   = rw;
         prev_addr = a;
         prev_wd   = d;
         if (rw) begin
            ref_mem[a] = d;
         end else begin
            s2 = (cyc + 2) % 4;
            if (id) ev1[s2] = 1'b1; else ev0[s2] = 1'b1;
            ed[s2] = ref_mem[a];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (last_g == 0) req0 = 1'b0;
      if (last_g == 1) req1 = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_sram_rw", sram_rw, 1'b0);
      chk("rst_sram_addr", sram_addr, '0);
      chk("rst_sram_din", sram_din, '0);
      chk("rst_rvalid0", rvalid0, 1'b0);
      chk("rst_rvalid1", rvalid1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_slots();
      m_last   = 1'b1;
      prev_acc = 1'b0;
   endtask

   int cnt0, cnt1;
   int gseq [6];

   initial begin
      req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int a = 0; a < 16; a++) ref_mem[a] = init_val(a);
      clear_slots();
      @(posedge clk);
      #1;
      do_reset();

      // Same-cycle write (req1) and read (req0) to addr 7: read goes first.
      rd0_q.delete(); rd1_q.delete();
      req1 = 1; rw1 = 1; addr1 = 4'd7; wdata1 = 8'h3C;
      req0 = 1; rw0 = 0; addr0 = 4'd7;
      cycle();
      chk("t4_first_winner", last_g, 0);
      req0 = 1;
      cycle();
      chk("t4_second_winner", last_g, 1);
      cycle();
      repeat (3) cycle();
      chk("t4_nreads", rd0_q.size(), 2);
      chk("t4_old", rd0_q[0], init_val(7));
      chk("t4_new", rd0_q[1], 8'h3C);

      // Write then read of addr 3 by master 0.
      rd0_q.delete(); rd1_q.delete();
      req0 = 1; rw0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
      cycle();
      req0 = 1; rw0 = 0;
      cycle();
      repeat (3) cycle();
      chk("t2_nreads", rd0_q.size(), 1);
      chk("t2_rdata", rd0_q[0], 8'hA5);
      chk("t2_no_rvalid1", rd1_q.size(), 0);

      // Idle cycles leave the round-robin pointer alone (master 0 won last).
      repeat (4) cycle();
      req0 = 1; rw0 = 0; addr0 = 4'd4;
      req1 = 1; rw1 = 0; addr1 = 4'd5;
      cycle();
      chk("t5_winner", last_g, 1);
      cycle();
      repeat (3) cycle();

      // Reset with a read in flight: dropped, never returned.
      rd0_q.delete(); rd1_q.delete();
      req0 = 1; rw0 = 0; addr0 = 4'd5;
      cycle();
      req0 = 0; req1 = 0;
      do_reset();
      repeat (4) cycle();
      chk("t1_no_return", rd0_q.size() + rd1_q.size(), 0);

      // Continuous contention for six reads.
      rd0_q.delete(); rd1_q.delete();
      cnt0 = 0; cnt1 = 0;
      req0 = 1; rw0 = 0; addr0 = 4'd1;
      req1 = 1; rw1 = 0; addr1 = 4'd2;
      for (int i = 0; i < 6; i++) begin
         cycle();
         gseq[i] = last_g;
         if (last_g == 0) cnt0++;
         if (last_g == 1) cnt1++;
         req0 = (cnt0 < 3);
         req1 = (cnt1 < 3);
      end
      req0 = 0; req1 = 0;
      for (int i = 0; i < 6; i++) chk("t3_order", gseq[i], i % 2);
      repeat (3) cycle();
      chk("t3_n0", rd0_q.size(), 3);
      chk("t3_n1", rd1_q.size(), 3);
      chk("t3_d0", rd0_q[0], ref_mem[1]);
      chk("t3_d1", rd1_q[0], ref_mem[2]);
`ifdef SRAM_ARB_STATS_EN
      chk("t6_gnt_cnt0", gnt_cnt0, 16'd3);
      chk("t6_gnt_cnt1", gnt_cnt1, 16'd3);
      chk("t6_conflict", (conflict_cnt >= 16'd5), 1'b1);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if (!req0 && ($urandom_range(3) != 0)) begin
            req0 = 1; rw0 = 1'($urandom_range(1));
            addr0 = 4'($urandom_range(15)); wdata0 = 8'($urandom);
         end
         if (!req1 && ($urandom_range(3) != 0)) begin
            req1 = 1; rw1 = 1'($urandom_range(1));
            addr1 = 4'($urandom_range(15)); wdata1 = 8'($urandom);
         end
         cycle();
      end
      req0 = 0; req1 = 0;
      repeat (4) cycle();

`ifdef SRAM_ARB_STATS_EN
      // Saturation of the grant counter.
      req0 = 1; rw0 = 0; addr0 = 4'd0;
      repeat (65540) @(posedge clk);
      #1;
      req0 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_sat", gnt_cnt0, 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
